// File: rtl/tls_ctrl.sv
// Sequencing controller for one TLS instance: owns the timing-profile table and
// steers the light through load, pedestrian, hold, emergency and safe states.
module tls_ctrl #(
   parameter int unsigned PED_EXT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] prof_sel,
   input  logic       cfg_we,
   input  logic [1:0] cfg_addr,
   input  logic [3:0] cfg_g,
   input  logic [3:0] cfg_y,
   input  logic [3:0] cfg_r,
   input  logic       ped_req,
   input  logic       emg_req,
   input  logic       hold,
   input  logic       Gout,
   input  logic       Yout,
   input  logic       Rout,
   output logic       Set,
   output logic       Stop,
   output logic       Jump,
   output logic [3:0] Gin,
   output logic [3:0] Yin,
   output logic [3:0] Rin,
   output logic       ped_ack,
   output logic       fault,
   output logic [2:0] ctrl_state
);

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_HOLD  = 3'd3,
      S_PED   = 3'd4,
      S_EMG_J = 3'd5,
      S_EMG   = 3'd6,
      S_SAFE  = 3'd7
   } state_e;

   localparam logic [3:0] PED_LAST = 4'(PED_EXT - 1);

   state_e     state_q, state_d;
   logic [1:0] active_prof_q, active_prof_d;
   logic       ped_pend_q, ped_pend_d;
   logic       reload_q, reload_d;
   logic       g_prev_q, r_prev_q;
   logic       bad_q, bad_d;
   logic [3:0] ped_cnt_q, ped_cnt_d;
   logic       set_q, set_d, stop_q, stop_d, jump_q, jump_d;
   logic       ped_ack_q, ped_ack_d, fault_q, fault_d;
   logic [3:0] gin_q, gin_d, yin_q, yin_d, rin_q, rin_d;
   logic [3:0] tbl_g_q [4];
   logic [3:0] tbl_y_q [4];
   logic [3:0] tbl_r_q [4];

   logic lamp_bad, monitored, fault_det, g_rise, r_rise, ped_pend_now, reload_now;
   logic load_entry, ped_entry;

   // A zero duration would make the TLS counter wrap to a 16-cycle phase.
   function automatic logic [3:0] nz(input logic [3:0] v);
      return (v == 4'd0) ? 4'd1 : v;
   endfunction

   assign lamp_bad     = !$onehot({Gout, Yout, Rout});
   assign monitored    = (state_q == S_RUN) || (state_q == S_HOLD) || (state_q == S_PED);
   assign fault_det    = monitored && lamp_bad && bad_q;
   assign g_rise       = Gout && !g_prev_q;
   assign r_rise       = Rout && !r_prev_q;
   assign ped_pend_now = ped_pend_q || ped_req;
   assign reload_now   = reload_q || (prof_sel != active_prof_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:  state_d = S_LOAD;
         S_LOAD:  state_d = S_RUN;
         S_RUN: begin
            if (fault_det)                   state_d = S_SAFE;
            else if (emg_req)                state_d = S_EMG_J;
            else if (hold)                   state_d = S_HOLD;
            else if (r_rise && ped_pend_now) state_d = S_PED;
            else if (g_rise && reload_now)   state_d = S_LOAD;
         end
         S_HOLD: begin
            if (fault_det)    state_d = S_SAFE;
            else if (emg_req) state_d = S_EMG_J;
            else if (!hold)   state_d = S_RUN;
         end
         S_PED: begin
            if (fault_det)                 state_d = S_SAFE;
            else if (emg_req)              state_d = S_EMG_J;
            else if (ped_cnt_q == 4'd0)    state_d = S_RUN;
         end
         S_EMG_J: state_d = S_EMG;
         S_EMG:   if (!emg_req) state_d = S_RUN;
         S_SAFE:  state_d = S_SAFE;
         default: state_d = S_SAFE;
      endcase
   end

   // Registered outputs are decoded from the state being entered.
   always_comb begin
      load_entry    = (state_d == S_LOAD);
      ped_entry     = (state_d == S_PED) && (state_q != S_PED);
      active_prof_d = load_entry ? prof_sel : active_prof_q;
      gin_d         = load_entry ? nz(tbl_g_q[prof_sel]) : gin_q;
      yin_d         = load_entry ? nz(tbl_y_q[prof_sel]) : yin_q;
      rin_d         = load_entry ? nz(tbl_r_q[prof_sel]) : rin_q;
      reload_d      = load_entry ? 1'b0 : reload_q;
      if (cfg_we && (cfg_addr == active_prof_d)) reload_d = 1'b1;
      ped_pend_d = ped_pend_q;
      if (ped_entry)                          ped_pend_d = 1'b0;
      else if (ped_req && state_q != S_SAFE)  ped_pend_d = 1'b1;
      ped_cnt_d = ped_cnt_q;
      if (ped_entry)                                   ped_cnt_d = PED_LAST;
      else if (state_q == S_PED && ped_cnt_q != 4'd0)  ped_cnt_d = ped_cnt_q - 4'd1;
      bad_d     = monitored && lamp_bad;
      set_d     = load_entry;
      jump_d    = (state_d == S_EMG_J) || (state_d == S_SAFE && state_q != S_SAFE);
      stop_d    = (state_d == S_HOLD) || (state_d == S_PED) || (state_d == S_EMG) ||
                  (state_d == S_SAFE && state_q == S_SAFE);
      ped_ack_d = ped_entry;
      fault_d   = fault_q || (state_d == S_SAFE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_INIT;
         active_prof_q <= 2'd0;
         ped_pend_q    <= 1'b0;
         reload_q      <= 1'b0;
         g_prev_q      <= 1'b0;
         r_prev_q      <= 1'b0;
         bad_q         <= 1'b0;
         ped_cnt_q     <= 4'd0;
         set_q         <= 1'b0;
         stop_q        <= 1'b0;
         jump_q        <= 1'b0;
         ped_ack_q     <= 1'b0;
         fault_q       <= 1'b0;
         gin_q         <= 4'd0;
         yin_q         <= 4'd0;
         rin_q         <= 4'd0;
      end else begin
         state_q       <= state_d;
         active_prof_q <= active_prof_d;
         ped_pend_q    <= ped_pend_d;
         reload_q      <= reload_d;
         g_prev_q      <= Gout;
         r_prev_q      <= Rout;
         bad_q         <= bad_d;
         ped_cnt_q     <= ped_cnt_d;
         set_q         <= set_d;
         stop_q        <= stop_d;
         jump_q        <= jump_d;
         ped_ack_q     <= ped_ack_d;
         fault_q       <= fault_d;
         gin_q         <= gin_d;
         yin_q         <= yin_d;
         rin_q         <= rin_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tbl_g_q[0] <= 4'd8;  tbl_y_q[0] <= 4'd2; tbl_r_q[0] <= 4'd6;
         tbl_g_q[1] <= 4'd12; tbl_y_q[1] <= 4'd3; tbl_r_q[1] <= 4'd8;
         tbl_g_q[2] <= 4'd4;  tbl_y_q[2] <= 4'd2; tbl_r_q[2] <= 4'd4;
         tbl_g_q[3] <= 4'd6;  tbl_y_q[3] <= 4'd2; tbl_r_q[3] <= 4'd6;
      end else if (cfg_we) begin
         tbl_g_q[cfg_addr] <= cfg_g;
         tbl_y_q[cfg_addr] <= cfg_y;
         tbl_r_q[cfg_addr] <= cfg_r;
      end
   end

   assign Set        = set_q;
   assign Stop       = stop_q;
   assign Jump       = jump_q;
   assign Gin        = gin_q;
   assign Yin        = yin_q;
   assign Rin        = rin_q;
   assign ped_ack    = ped_ack_q;
   assign fault      = fault_q;
   assign ctrl_state = state_q;

endmodule

// File: tb/tb_tls_ctrl.sv
// Directed bench for tls_ctrl: lamp feedback is driven by hand and every
// observed cycle is compared with a hand-computed {state, controls, durations}.
module tb_tls_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] prof_sel, cfg_addr;
   logic       cfg_we, ped_req, emg_req, hold;
   logic [3:0] cfg_g, cfg_y, cfg_r;
   logic       Gout, Yout, Rout;
   logic       Set, Stop, Jump, ped_ack, fault;
   logic [3:0] Gin, Yin, Rin;
   logic [2:0] ctrl_state;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic [19:0] exp_v;

   localparam logic [2:0] L_G = 3'b100, L_Y = 3'b010, L_R = 3'b001;
   // control field order: {Set, Stop, Jump, ped_ack, fault}
   localparam logic [4:0] C_NONE = 5'b00000, C_SET = 5'b10000, C_STOP = 5'b01000,
                          C_JUMP = 5'b00100, C_PED = 5'b01010, C_SJ = 5'b00101,
                          C_SS = 5'b01001;

   tls_ctrl #(.PED_EXT(4)) dut (
      .clk(clk), .reset(reset), .prof_sel(prof_sel), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_g(cfg_g), .cfg_y(cfg_y), .cfg_r(cfg_r),
      .ped_req(ped_req), .emg_req(emg_req), .hold(hold),
      .Gout(Gout), .Yout(Yout), .Rout(Rout),
      .Set(Set), .Stop(Stop), .Jump(Jump), .Gin(Gin), .Yin(Yin), .Rin(Rin),
      .ped_ack(ped_ack), .fault(fault), .ctrl_state(ctrl_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   function automatic logic [19:0] obs();
      return {ctrl_state, Set, Stop, Jump, ped_ack, fault, Gin, Yin, Rin};
   endfunction

   function automatic logic [19:0] pk(input logic [2:0] st, input logic [4:0] c,
                                      input logic [3:0] g, input logic [3:0] y, input logic [3:0] r);
      return {st, c, g, y, r};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lamps(input logic [2:0] v);
      {Gout, Yout, Rout} = v;
   endtask

   task automatic test_reset();
      reset = 1'b0; prof_sel = 2'd0; cfg_we = 1'b0; cfg_addr = 2'd0;
      cfg_g = 4'd0; cfg_y = 4'd0; cfg_r = 4'd0;
      ped_req = 1'b0; emg_req = 1'b0; hold = 1'b0; lamps(L_R);
      #12;
      exp_v = pk(3'd0, C_NONE, 4'd0, 4'd0, 4'd0);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL reset_values: got %h required %h", obs(), exp_v); end
      reset = 1'b1;
      tick();
      exp_v = pk(3'd1, C_SET, 4'd8, 4'd2, 4'd6);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL default_load: got %h required %h", obs(), exp_v); end
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_v = pk(3'd2, C_NONE, 4'd8, 4'd2, 4'd6);
         vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL run_after_load[%0d]: got %h required %h", i, obs(), exp_v); end
      end
   endtask

   task automatic test_profile_change();
      prof_sel = 2'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_v = pk(3'd2, C_NONE, 4'd8, 4'd2, 4'd6);
         vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL prof_wait_green[%0d]: got %h required %h", i, obs(), exp_v); end
      end
      lamps(L_G); tick();
      exp_v = pk(3'd1, C_SET, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL prof_load: got %h required %h", obs(), exp_v); end
      for (int i = 0; i < 2; i++) begin
         tick();
         exp_v = pk(3'd2, C_NONE, 4'd12, 4'd3, 4'd8);
         vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL prof_run[%0d]: got %h required %h", i, obs(), exp_v); end
      end
   endtask

   task automatic test_pedestrian();
      ped_req = 1'b1; tick(); tick(); ped_req = 1'b0;
      lamps(L_Y); tick();
      exp_v = pk(3'd2, C_NONE, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL ped_wait_red: got %h required %h", obs(), exp_v); end
      lamps(L_R); tick();
      exp_v = pk(3'd4, C_PED, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL ped_start: got %h required %h", obs(), exp_v); end
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_v = pk(3'd4, C_STOP, 4'd12, 4'd3, 4'd8);
         vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL ped_stop[%0d]: got %h required %h", i, obs(), exp_v); end
      end
      tick();
      exp_v = pk(3'd2, C_NONE, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL ped_end: got %h required %h", obs(), exp_v); end
      lamps(L_G); tick(); lamps(L_Y); tick(); lamps(L_R); tick();
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL ped_no_second_ext: got %h required %h", obs(), exp_v); end
   endtask

   task automatic test_ped_same_cycle();
      lamps(L_G); tick();
      lamps(L_R); ped_req = 1'b1; tick(); ped_req = 1'b0;
      exp_v = pk(3'd4, C_PED, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL ped_same_cycle: got %h required %h", obs(), exp_v); end
      repeat (3) tick();
      tick();
      exp_v = pk(3'd2, C_NONE, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL ped_same_cycle_end: got %h required %h", obs(), exp_v); end
   endtask

   task automatic test_emergency();
      lamps(L_G); tick(); lamps(L_Y); tick();
      emg_req = 1'b1; tick();
      exp_v = pk(3'd5, C_JUMP, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL emg_jump: got %h required %h", obs(), exp_v); end
      lamps(L_R);
      for (int i = 0; i < 9; i++) begin
         tick();
         exp_v = pk(3'd6, C_STOP, 4'd12, 4'd3, 4'd8);
         vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL emg_stop[%0d]: got %h required %h", i, obs(), exp_v); end
      end
      emg_req = 1'b0; tick();
      exp_v = pk(3'd2, C_NONE, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL emg_release: got %h required %h", obs(), exp_v); end
   endtask

   task automatic test_ped_abort();
      lamps(L_G); ped_req = 1'b1; tick(); ped_req = 1'b0;
      lamps(L_R); tick();
      exp_v = pk(3'd4, C_PED, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL abort_ped_start: got %h required %h", obs(), exp_v); end
      emg_req = 1'b1; tick();
      exp_v = pk(3'd5, C_JUMP, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL abort_to_emg: got %h required %h", obs(), exp_v); end
      tick(); emg_req = 1'b0; tick();
      lamps(L_G); tick(); lamps(L_R); tick();
      exp_v = pk(3'd2, C_NONE, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL abort_pend_clear: got %h required %h", obs(), exp_v); end
   endtask

   task automatic test_hold();
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_v = pk(3'd3, C_STOP, 4'd12, 4'd3, 4'd8);
         vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL hold_stop[%0d]: got %h required %h", i, obs(), exp_v); end
      end
      hold = 1'b0; tick();
      exp_v = pk(3'd2, C_NONE, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL hold_release: got %h required %h", obs(), exp_v); end
      hold = 1'b1; tick(); emg_req = 1'b1; tick();
      exp_v = pk(3'd5, C_JUMP, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL hold_to_emg: got %h required %h", obs(), exp_v); end
      hold = 1'b0; tick();
      exp_v = pk(3'd6, C_STOP, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL hold_emg_stop: got %h required %h", obs(), exp_v); end
      emg_req = 1'b0; tick();
   endtask

   task automatic test_clamp();
      cfg_we = 1'b1; cfg_addr = 2'd2; cfg_g = 4'd0; cfg_y = 4'd0; cfg_r = 4'd0; tick(); cfg_we = 1'b0;
      lamps(L_R); tick(); lamps(L_G); tick();
      exp_v = pk(3'd2, C_NONE, 4'd12, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL cfg_other_no_reload: got %h required %h", obs(), exp_v); end
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_g = 4'd0; cfg_y = 4'd3; cfg_r = 4'd8; tick(); cfg_we = 1'b0;
      lamps(L_R); tick(); lamps(L_G); tick();
      exp_v = pk(3'd1, C_SET, 4'd1, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL clamp_green: got %h required %h", obs(), exp_v); end
      cfg_we = 1'b1; cfg_g = 4'd5; cfg_y = 4'd6; cfg_r = 4'd7; tick(); cfg_we = 1'b0;
      exp_v = pk(3'd2, C_NONE, 4'd1, 4'd3, 4'd8);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL write_in_load_hold: got %h required %h", obs(), exp_v); end
      lamps(L_R); tick(); lamps(L_G); tick();
      exp_v = pk(3'd1, C_SET, 4'd5, 4'd6, 4'd7);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL write_in_load_reload: got %h required %h", obs(), exp_v); end
      tick(); prof_sel = 2'd2;
      lamps(L_R); tick(); lamps(L_G); tick();
      exp_v = pk(3'd1, C_SET, 4'd1, 4'd1, 4'd1);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL clamp_all_zero: got %h required %h", obs(), exp_v); end
      tick();
   endtask

   task automatic test_fault();
      lamps(3'b000); tick(); lamps(L_G); tick();
      exp_v = pk(3'd2, C_NONE, 4'd1, 4'd1, 4'd1);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL single_glitch_no_fault: got %h required %h", obs(), exp_v); end
      lamps(3'b101); tick();
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL first_bad_no_fault: got %h required %h", obs(), exp_v); end
      tick();
      exp_v = pk(3'd7, C_SJ, 4'd1, 4'd1, 4'd1);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL fault_jump: got %h required %h", obs(), exp_v); end
      ped_req = 1'b1; emg_req = 1'b1; hold = 1'b1; prof_sel = 2'd0; lamps(L_R);
      for (int i = 0; i < 5; i++) begin
         tick();
         exp_v = pk(3'd7, C_SS, 4'd1, 4'd1, 4'd1);
         vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL safe_stuck[%0d]: got %h required %h", i, obs(), exp_v); end
      end
      ped_req = 1'b0; emg_req = 1'b0; hold = 1'b0;
   endtask

   task automatic test_reset_recover();
      reset = 1'b0; #2;
      exp_v = pk(3'd0, C_NONE, 4'd0, 4'd0, 4'd0);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL async_reset: got %h required %h", obs(), exp_v); end
      prof_sel = 2'd2; reset = 1'b1; tick();
      exp_v = pk(3'd1, C_SET, 4'd4, 4'd2, 4'd4);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL table_default_restored: got %h required %h", obs(), exp_v); end
      tick();
      exp_v = pk(3'd2, C_NONE, 4'd4, 4'd2, 4'd4);
      vec_cnt++; if (obs() !== exp_v) begin err_cnt++; $display("FAIL run_after_recover: got %h required %h", obs(), exp_v); end
   endtask

   initial begin
      test_reset();
      test_profile_change();
      test_pedestrian();
      test_ped_same_cycle();
      test_emergency();
      test_ped_abort();
      test_hold();
      test_clamp();
      test_fault();
      test_reset_recover();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/tls_ctrl.md
# tls_ctrl

Sequencing controller for one TLS traffic-light instance. It owns a four-entry timing-profile table and drives the TLS `Set`/`Stop`/`Jump` and `Gin`/`Yin`/`Rin` inputs. It monitors the TLS `Gout`/`Yout`/`Rout` lamps to serve pedestrian extensions, emergency pre-emption, operator hold and profile changes, and it forces a safe all-red on lamp fault.

## Interface
- `PED_EXT`, default 4: extra red cycles granted per pedestrian request (1–15).
- `clk`, input, 1: rising-edge clock shared with the TLS.
- `reset`, input, 1: **asynchronous, active-low** reset.
- `prof_sel`, input, 2: requested timing profile.
- `cfg_we`, input, 1: profile-table write strobe.
- `cfg_addr`, input, 2: profile index to write.
- `cfg_g`, `cfg_y`, `cfg_r`, input, 4 each: green/yellow/red durations to write.
- `ped_req`, input, 1: pedestrian button; a single-cycle pulse is sufficient.
- `emg_req`, input, 1: emergency pre-emption, level-sensitive.
- `hold`, input, 1: operator freeze, level-sensitive.
- `Gout`, `Yout`, `Rout`, input, 1 each: lamp feedback from the TLS.
- `Set`, `Stop`, `Jump`, output, 1 each: TLS control.
- `Gin`, `Yin`, `Rin`, output, 4 each: TLS durations.
- `ped_ack`, output, 1: one-cycle pulse when a pedestrian extension starts.
- `fault`, output, 1: sticky lamp-fault flag.
- `ctrl_state`, output, 3: current controller state encoding.

## Operation
- States and encodings: INIT=0, LOAD=1, RUN=2, HOLD=3, PED=4, EMG_J=5, EMG=6, SAFE=7.
- All outputs are registered. At most one of `Set`/`Stop`/`Jump` may be high in any cycle; this is an invariant.
- Reset values:
  - `Set`=`Stop`=`Jump`=0, `Gin`=`Yin`=`Rin`=0, `ped_ack`=0, `fault`=0.
  - State INIT, `active_prof`=0, `ped_pend`=0.
  - Table contents: P0={8,2,6}, P1={12,3,8}, P2={4,2,4}, P3={6,2,6}, given as {G,Y,R}.
- INIT goes to LOAD on the next cycle.
- LOAD:
  - Latches `prof_sel` into `active_prof`.
  - Drives `Set`=1 for exactly one cycle with `Gin`/`Yin`/`Rin` = table[`active_prof`], then goes to RUN.
  - Any table value of 0 is driven as 1, so the TLS never wraps to a 16-cycle phase.
  - `Gin`/`Yin`/`Rin` hold their last loaded values at all other times.
- Table write: when `cfg_we`=1, the entry at `cfg_addr` is written at the clock edge in any state. If `cfg_addr`==`active_prof`, a reload is pending.
- Reload pending: set when `prof_sel`≠`active_prof` or on a write to the active entry. It is served in RUN on the cycle after a `Gout` rising edge is sampled: go to LOAD.
- RUN transitions, highest priority first:
  1. Lamp fault → SAFE.
  2. `emg_req` → EMG_J.
  3. `hold` → HOLD.
  4. Pedestrian service → PED.
  5. Pending reload → LOAD.
- Pedestrian service:
  - `ped_req` sets `ped_pend` in any state except SAFE.
  - Served in RUN on the cycle after a `Rout` rising edge is sampled.
  - PED drives `Stop`=1 for `PED_EXT` cycles. `ped_ack` pulses in the first PED cycle and `ped_pend` clears.
  - Returns to RUN.
  - `emg_req` arriving during PED aborts PED to EMG_J. `ped_pend` stays clear.
- HOLD: `Stop`=1 while `hold`=1. Returns to RUN the cycle after `hold` falls. `emg_req` in HOLD → EMG_J.
- EMG_J → EMG:
  - EMG_J drives `Jump`=1 for one cycle; the TLS goes to red with count 0.
  - EMG drives `Stop`=1 while `emg_req`=1.
  - When `emg_req` falls: release `Stop` and go to RUN. Red then runs its full programmed duration.
- Lamp fault:
  - Condition: {`Gout`,`Yout`,`Rout`} not one-hot for 2 consecutive sampled cycles while in RUN, HOLD or PED.
  - Response: `fault`=1 (sticky), then SAFE.
  - SAFE drives `Jump`=1 for one cycle, then `Stop`=1 permanently. It ignores every input until `reset` is asserted.
- Reset mid-operation: all registers return to their reset values immediately (asynchronous). Table contents revert to the defaults.

## Timing
- Inputs are sampled at the rising edge. Responding outputs appear after that same edge, so the TLS acts on them at the following edge.
- Lamp-edge detection uses the registered previous value of each lamp.
- Service latency from a sampled `Gout`/`Rout` rising edge to the corresponding `Set`/`Stop` output: 1 cycle.
- `emg_req` rising edge → `Jump` high after 1 edge. `Stop` follows on the next cycle.
- LOAD lasts 1 cycle. PED lasts exactly `PED_EXT` cycles. EMG_J lasts 1 cycle.
- Simultaneous `ped_req` and lamp event: `ped_pend` is set and tested in the same cycle, and is served.
- `cfg_we` together with LOAD: LOAD drives the value stored before the write, and the reload then becomes pending.

## Test plan
- **Reset and default load.** Release `reset`, `prof_sel`=0. Expect `Set` high for 1 cycle with `Gin`/`Yin`/`Rin`=8/2/6, then TLS lamps cycling G8, Y2, R6; `ctrl_state`=2.
- **Profile change.** Switch `prof_sel` to 1 mid-red. Expect no `Set` until the next `Gout` rise; one cycle later `Set` with 12/3/8; green then lasts 12 cycles.
- **Pedestrian.** Pulse `ped_req` during green with `PED_EXT`=4. Expect `ped_ack` 1 cycle after `Rout` rises and `Stop` for 4 cycles; red lasts 6+4 cycles. A second `ped_req` in the same cycle must not add a second extension.
- **Emergency.** Assert `emg_req` during yellow for 10 cycles. Expect `Jump` next cycle, then `Stop` held, `Rout`=1 throughout; after release, red lasts 6 cycles, then green.
- **Zero-duration clamp.** Write P0={0,2,6} with P0 active. Expect the reload at the next green with `Gin`=1; green lasts 1 cycle.
- **Fault.** Force `Gout`=`Rout`=1 for 2 cycles. Expect `fault`=1, `Jump` for 1 cycle, then `Stop` stuck; `ped_req`/`emg_req` are ignored until `reset`.
